// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment reader: active-low hex glyphs and FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PUBLISH
  } state_e;

endpackage

// File: rtl/seg7_reader_glyph_decoder.sv
// Maps an active-low segment pattern back to its hex nibble; unknown patterns flag invalid.
module seg7_glyph_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] segments_i,
  output logic [3:0] nibble_o,
  output logic       invalid_o
);

  always_comb begin
    nibble_o  = 4'h0;
    invalid_o = 1'b0;
    case (segments_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Recovers the hex word shown on a scanned seven-segment display, one frame per full digit set.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                    clock_i,
  input  logic                    resetn_i,
  input  logic                    enable_i,
  input  logic [NUM_DIGITS-1:0]   digit_sel_i,
  input  logic [6:0]              segments_i,
  output logic [4*NUM_DIGITS-1:0] value_o,
  output logic [NUM_DIGITS-1:0]   bad_mask_o,
  output logic                    valid_o,
  output logic                    error_o
);

  localparam int unsigned   CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   sel_q;
  logic [6:0]              seg_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   captured_q, captured_d;
  logic [4*NUM_DIGITS-1:0] stage_val_q, stage_val_d;
  logic [NUM_DIGITS-1:0]   stage_bad_q, stage_bad_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   bad_q, bad_d;
  logic                    err_q, err_d;
  logic                    onehot_in;
  logic [3:0]              nibble;
  logic                    invalid;

  seg7_glyph_decoder u_decoder (
    .segments_i (seg_q),
    .nibble_o   (nibble),
    .invalid_o  (invalid)
  );

  assign onehot_in = (digit_sel_i != '0) &&
                     ((digit_sel_i & (digit_sel_i - NUM_DIGITS'(1))) == '0);

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      seg_q       <= '0;
      cnt_q       <= '0;
      captured_q  <= '0;
      stage_val_q <= '0;
      stage_bad_q <= '0;
      value_q     <= '0;
      bad_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= digit_sel_i;
      seg_q       <= segments_i;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      stage_val_q <= stage_val_d;
      stage_bad_q <= stage_bad_d;
      value_q     <= value_d;
      bad_q       <= bad_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    captured_d  = captured_q;
    stage_val_d = stage_val_q;
    stage_bad_d = stage_bad_q;
    value_d     = value_q;
    bad_d       = bad_q;
    err_d       = err_q;

    // Counter tracks the sample being registered this edge, so cnt_d==S-1 implies
    // the incoming pattern already equals the held sample the decoder is looking at.
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (({digit_sel_i, segments_i} != {sel_q, seg_q}) || !onehot_in) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        captured_d  = '0;
        stage_val_d = '0;
        stage_bad_d = '0;
        if (enable_i) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (&captured_q) begin
          state_d = ST_PUBLISH;
          value_d = stage_val_q;
          bad_d   = stage_bad_q;
          err_d   = |stage_bad_q;
        end else if (cnt_d == CNT_CAP) begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q[i] && !captured_q[i]) begin
              captured_d[i]       = 1'b1;
              stage_val_d[4*i +: 4] = nibble;
              stage_bad_d[i]      = invalid;
            end
          end
        end
      end
      ST_PUBLISH: begin
        captured_d  = '0;
        stage_bad_d = '0;
        state_d     = enable_i ? ST_SCAN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign value_o    = value_q;
  assign bad_mask_o = bad_q;
  assign error_o    = err_q;
  assign valid_o    = (state_q == ST_PUBLISH);

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: table-driven full scans, hand-written corner sequences, randomized traffic.
module tb_seg7_reader;

  localparam int N = 4;
  localparam int S = 8;

  logic          clock = 1'b0;
  logic          resetn;
  logic          enable;
  logic [N-1:0]  digit_sel;
  logic [6:0]    segments;
  logic [4*N-1:0] value;
  logic [N-1:0]  bad_mask;
  logic          valid;
  logic          error;

  seg7_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clock_i     (clock),
    .resetn_i    (resetn),
    .enable_i    (enable),
    .digit_sel_i (digit_sel),
    .segments_i  (segments),
    .value_o     (value),
    .bad_mask_o  (bad_mask),
    .valid_o     (valid),
    .error_o     (error)
  );

  always #5 clock = ~clock;

  logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame contents plus a run of consecutive identical samples.
  typedef logic [N+6:0] smp_t;
  smp_t        hist[$];
  int          mstate;          // 0 idle, 1 scanning, 2 publishing
  logic [N-1:0]   mcap, mbad;
  logic [4*N-1:0] mstage;
  logic [4*N-1:0] e_value;
  logic [N-1:0]   e_bad;
  logic           e_err, e_valid;

  int             vcount;
  logic [4*N-1:0] last_val;
  logic [N-1:0]   last_bad;
  logic           last_err;
  logic           prev_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int glyph_index(input logic [6:0] seg);
    for (int g = 0; g < 16; g++) if (GLY[g] == seg) return g;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    mstate = 0; mcap = '0; mbad = '0; mstage = '0;
    e_value = '0; e_bad = '0; e_err = 1'b0; e_valid = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] sel, input logic [6:0] seg, input logic en);
    smp_t smp = {sel, seg};
    bit   oh = ($countones(sel) == 1);
    bit   reached = 0;
    bit   full = &mcap;
    int   ns = mstate;
    int   g;
    if (mstate == 0 || !oh || hist.size() == 0 || hist[$] != smp) begin
      hist.delete();
      hist.push_back(smp);
    end else if (hist.size() < S) begin
      hist.push_back(smp);
      reached = (hist.size() == S);
    end
    case (mstate)
      0: begin
        mcap = '0; mbad = '0; mstage = '0;
        ns = en ? 1 : 0;
      end
      1: begin
        if (!en) ns = 0;
        else if (full) begin
          ns = 2; e_value = mstage; e_bad = mbad; e_err = |mbad;
        end else if (reached && oh) begin
          for (int d = 0; d < N; d++) begin
            if (sel[d] && !mcap[d]) begin
              g = glyph_index(seg);
              mcap[d] = 1'b1;
              mstage[4*d +: 4] = (g < 0) ? 4'h0 : 4'(g);
              mbad[d] = (g < 0);
            end
          end
        end
      end
      default: begin
        mcap = '0; mbad = '0;
        ns = en ? 1 : 0;
      end
    endcase
    mstate  = ns;
    e_valid = (ns == 2);
  endtask

  task automatic tick(input logic [N-1:0] sel, input logic [6:0] seg, input logic en);
    digit_sel = sel; segments = seg; enable = en;
    @(posedge clock);
    model_step(sel, seg, en);
    #1;
    chk("valid", valid, e_valid);
    chk("value", value, e_value);
    chk("bad_mask", bad_mask, e_bad);
    chk("error", error, e_err);
    if (valid && prev_valid) chk("valid_back_to_back", 1, 0);
    prev_valid = valid;
    if (valid) begin
      vcount++; last_val = value; last_bad = bad_mask; last_err = error;
    end
  endtask

  task automatic scan_digit(input int d, input logic [6:0] seg, input int n);
    for (int c = 0; c < n; c++) tick(N'(1 << d), seg, 1'b1);
  endtask

  task automatic blanks(input int n);
    for (int c = 0; c < n; c++) tick('0, 7'h7F, 1'b1);
  endtask

  typedef struct {
    logic [27:0]    segs;   // {d3, d2, d1, d0}
    logic [4*N-1:0] val;
    logic [N-1:0]   bad;
  } row_t;

  row_t rows[7];

  initial begin
    rows[0] = '{ {7'h0E, 7'h08, 7'h12, 7'h30}, 16'hFA53, 4'b0000 };
    rows[1] = '{ {7'h0E, 7'h7F, 7'h12, 7'h30}, 16'hF053, 4'b0100 };
    rows[2] = '{ {7'h79, 7'h79, 7'h79, 7'h79}, 16'h1111, 4'b0000 };
    rows[3] = '{ {7'h30, 7'h24, 7'h79, 7'h40}, 16'h3210, 4'b0000 };
    rows[4] = '{ {7'h10, 7'h00, 7'h78, 7'h02}, 16'h9876, 4'b0000 };
    rows[5] = '{ {7'h06, 7'h21, 7'h46, 7'h03}, 16'hEDCB, 4'b0000 };
    rows[6] = '{ {7'h06, 7'h7F, 7'h12, 7'h55}, 16'hE050, 4'b0101 };

    resetn = 1'b0; enable = 1'b0; digit_sel = '0; segments = 7'h7F;
    prev_valid = 1'b0; vcount = 0; last_val = '0; last_bad = '0; last_err = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_value", value, 0);
    chk("reset_bad", bad_mask, 0);
    chk("reset_error", error, 0);
    chk("reset_valid", valid, 0);
    @(negedge clock) resetn = 1'b1;
    blanks(2);

    for (int r = 0; r < 7; r++) begin
      vcount = 0;
      for (int d = 0; d < N; d++) scan_digit(d, rows[r].segs[7*d +: 7], 10);
      blanks(4);
      chk("row_valid_count", vcount, 1);
      chk("row_value", last_val, rows[r].val);
      chk("row_bad", last_bad, rows[r].bad);
      chk("row_error", last_err, |rows[r].bad);
    end

    // Digit 1 flickers too fast to settle, then holds long enough.
    vcount = 0;
    scan_digit(0, 7'h30, 10);
    for (int t = 0; t < 8; t++) scan_digit(1, (t % 2) ? 7'h12 : 7'h30, 5);
    scan_digit(2, 7'h08, 10);
    scan_digit(3, 7'h0E, 10);
    blanks(4);
    chk("flicker_no_valid", vcount, 0);
    scan_digit(1, 7'h12, 10);
    blanks(4);
    chk("flicker_then_hold_valid", vcount, 1);
    chk("flicker_value", last_val, 16'hFA53);

    // Selects that are not one-hot never capture.
    vcount = 0;
    for (int c = 0; c < 20; c++) tick(4'b0011, 7'h79, 1'b1);
    for (int c = 0; c < 20; c++) tick(4'b0000, 7'h79, 1'b1);
    chk("not_onehot_no_valid", vcount, 0);
    for (int d = 0; d < N; d++) scan_digit(d, 7'h40, 10);
    blanks(3);
    chk("after_not_onehot_value", last_val, 16'h0000);

    // Enable drop discards a partial frame.
    vcount = 0;
    scan_digit(0, 7'h30, 10);
    scan_digit(1, 7'h12, 10);
    tick('0, 7'h7F, 1'b0);
    for (int d = 0; d < N; d++) scan_digit(d, 7'h79, 10);
    blanks(4);
    chk("enable_drop_valid_count", vcount, 1);
    chk("enable_drop_value", last_val, 16'h1111);

    // Asynchronous reset mid-frame after three captures.
    vcount = 0;
    scan_digit(0, 7'h06, 10);
    scan_digit(1, 7'h06, 10);
    scan_digit(2, 7'h06, 10);
    #2 resetn = 1'b0;
    #1;
    chk("midreset_value", value, 0);
    chk("midreset_valid", valid, 0);
    chk("midreset_error", error, 0);
    model_reset();
    @(negedge clock) resetn = 1'b1;
    prev_valid = 1'b0;
    blanks(2);
    scan_digit(0, 7'h40, 10);
    scan_digit(1, 7'h79, 10);
    scan_digit(2, 7'h24, 10);
    blanks(3);
    chk("post_reset_partial_no_valid", vcount, 0);
    scan_digit(3, 7'h30, 10);
    blanks(3);
    chk("post_reset_valid", vcount, 1);
    chk("post_reset_value", last_val, 16'h3210);

    // Randomized traffic against the model.
    for (int step = 0; step < 400; step++) begin
      logic [N-1:0] sel;
      logic [6:0]   seg;
      logic         en;
      int           hold;
      en   = ($urandom_range(0, 99) >= 4);
      sel  = ($urandom_range(0, 99) < 85) ? N'(1 << $urandom_range(0, N-1)) : N'($urandom_range(0, 15));
      seg  = ($urandom_range(0, 99) < 75) ? GLY[$urandom_range(0, 15)] : 7'($urandom_range(0, 127));
      hold = en ? $urandom_range(1, 13) : $urandom_range(1, 2);
      for (int c = 0; c < hold; c++) tick(sel, seg, en);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Multiplexed seven-segment display reader: watches the active-low segment bus and one-hot digit-select lines that drive a scanned HEX display, and recovers the displayed hex word. Each digit's pattern must hold steady before it is decoded back to its 4-bit value. A frame is published once every digit has been captured, with a flag for any pattern that is not one of the 16 hex glyphs. It sits on the display side of the hex decoder/scanner path and serves as the self-check and loopback monitor for that path.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 8, consecutive identical samples required before capture (≥2)
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  high = reader runs; low = abort frame, go IDLE
- digit_sel  in  NUM_DIGITS  one-hot active-high digit strobe; bit i = digit i
- segments  in  7  active-low segments, bit0=a … bit6=g
- value  out  4*NUM_DIGITS  last published word; digit i in bits [4i+3:4i]
- bad_mask  out  NUM_DIGITS  bit i set = digit i pattern was not a hex glyph in last frame
- valid  out  1  one-cycle pulse when value/bad_mask update
- error  out  1  OR of bad_mask, updated with valid

## Operation
- Glyph table, active-low hex: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E; any other pattern is invalid and decodes to nibble 0.
- Inputs are registered once into a sample {digit_sel, segments}; all logic uses the sample.
- Stability counter: reset to 0 when sample differs from previous sample or digit_sel is not one-hot (zero or multiple bits); otherwise increments, saturating at STABLE_CYCLES.
- FSM states: IDLE, SCAN, PUBLISH.
  - IDLE: counter, captured mask and staging cleared; enter SCAN when enable=1.
  - SCAN: when counter reaches STABLE_CYCLES-1 with a one-hot digit_sel whose captured bit is clear, write decoded nibble to staging slot i, set captured[i], and set staging bad[i] if invalid. A digit already captured this frame is ignored (first capture wins). When captured becomes all-ones, go PUBLISH.
  - PUBLISH: value<=staging, bad_mask<=staging bad, error<=|staging bad, valid=1; clear captured and staging bad; return to SCAN.
- enable=0 in any state: next state IDLE and partial frame discarded. value/bad_mask/error hold their last published contents.
- A digit held indefinitely captures only once per frame. Saturation prevents re-triggering.

## Timing
- Reset (async assert, sync release): state IDLE, value=0, bad_mask=0, error=0, valid=0, counter=0, captured=0.
- Pattern steady at the input before edge k: sampled at k; capture at edge k+STABLE_CYCLES-1 (counter 0 at k, STABLE_CYCLES-1 at the capture edge).
- Last digit captured at edge m: PUBLISH at m+1 (valid high for the cycle after edge m+1); SCAN again at m+2.
- The capture in the same cycle as the PUBLISH transition belongs to the closing frame. Captures cannot occur during PUBLISH; a digit that stabilises then is captured on its next qualifying sample in SCAN.
- Reset or enable drop mid-frame: no valid pulse for the partial frame.
- valid never high on two consecutive cycles.

## Structure
- Package seg7_pkg: 7-bit glyph constants SEG_0..SEG_F, blank pattern 7F, FSM state enum.
- Sub-module seg7_glyph_decoder: combinational segments[6:0] -> {nibble[3:0], invalid}. It is instantiated once on the sampled segments.
- Counter width = $clog2(STABLE_CYCLES+1).

## Test plan
- Reset, NUM_DIGITS=4, STABLE_CYCLES=8; scan digits 0..3 with 30,12,08,0E, 10 cycles each -> one valid pulse, value=16'hFA53, bad_mask=0, error=0.
- Same scan but digit 2 shows 7F (blank) -> value=16'hF053, bad_mask=4'b0100, error=1.
- Digit 1 toggles pattern every 5 cycles, others steady -> no capture of digit 1, no valid until digit 1 holds ≥8 cycles.
- digit_sel=4'b0011 or 4'b0000 held 20 cycles -> nothing captured, no valid.
- Digits 0,1 captured, then enable=0 for 1 cycle, then full scan of 79,79,79,79 -> exactly one valid, value=16'h1111.
- resetn asserted mid-frame after 3 captures -> outputs 0 immediately; the following full scan needs all 4 digits before valid.
